// File: rtl/reg_dc_mp.sv
// Decode-stage register read with a one-entry valid/ready output register.
// Optional write-back forwarding is enabled by defining REG_DC_MP_BYPASS_EN.
module reg_dc_mp #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2
) (
  input  logic                       CLK_DC,
  input  logic                       RESET,
  input  logic                       VALID_IN,
  output logic                       READY_OUT,
  input  logic [NUM_RD*ADDR_W-1:0]   N_REG_IN,
  input  logic [NUM_REGS*DATA_W-1:0] REGS_IN,
  input  logic                       WB_EN,
  input  logic [ADDR_W-1:0]          N_WB,
  input  logic [DATA_W-1:0]          WB_DATA,
  output logic                       VALID_OUT,
  input  logic                       READY_IN,
  output logic [NUM_RD*ADDR_W-1:0]   N_REG_OUT,
  output logic [NUM_RD*DATA_W-1:0]   REG_OUT,
  output logic [NUM_RD-1:0]          RANGE_ERR
);

  function automatic logic in_range(input logic [ADDR_W-1:0] idx);
    return (int'(idx) < NUM_REGS);
  endfunction

  // Out-of-range indices fall through every compare and read as zero.
  function automatic logic [DATA_W-1:0] read_reg(
    input logic [NUM_REGS*DATA_W-1:0] regs,
    input logic [ADDR_W-1:0]          idx
  );
    logic [DATA_W-1:0] v;
    v = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (idx == ADDR_W'(r)) v = regs[r*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  logic                     vld_p1_q, vld_p1_d;
  logic [NUM_RD*ADDR_W-1:0] nreg_p1_q, nreg_p1_d;
  logic [NUM_RD*DATA_W-1:0] data_p1_q, data_p1_d;
  logic [NUM_RD-1:0]        rerr_p1_q, rerr_p1_d;
  logic                     ready;
  logic                     accept;
  logic [ADDR_W-1:0]        idx_in [NUM_RD];

`ifndef REG_DC_MP_BYPASS_EN
  logic wb_unused;
  assign wb_unused = ^{WB_EN, N_WB, WB_DATA};
`endif

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) idx_in[p] = N_REG_IN[p*ADDR_W +: ADDR_W];
  end

  assign ready  = (!vld_p1_q || READY_IN) && !RESET;
  assign accept = VALID_IN && ready;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    nreg_p1_d = nreg_p1_q;
    data_p1_d = data_p1_q;
    rerr_p1_d = rerr_p1_q;
    if (accept) begin
      vld_p1_d  = 1'b1;
      nreg_p1_d = N_REG_IN;
      for (int p = 0; p < NUM_RD; p++) begin
        rerr_p1_d[p]                    = !in_range(idx_in[p]);
        data_p1_d[p*DATA_W +: DATA_W]   = read_reg(REGS_IN, idx_in[p]);
`ifdef REG_DC_MP_BYPASS_EN
        if (WB_EN && (N_WB == idx_in[p]) && in_range(N_WB))
          data_p1_d[p*DATA_W +: DATA_W] = WB_DATA;
`endif
      end
    end else if (vld_p1_q && READY_IN) begin
      vld_p1_d = 1'b0;
`ifdef REG_DC_MP_BYPASS_EN
    end else if (vld_p1_q) begin
      // Held operands track write-backs so the entry is not stale when it leaves.
      for (int p = 0; p < NUM_RD; p++) begin
        if (WB_EN && (N_WB == nreg_p1_q[p*ADDR_W +: ADDR_W]) && !rerr_p1_q[p])
          data_p1_d[p*DATA_W +: DATA_W] = WB_DATA;
      end
`endif
    end
  end

  // Stage p1: operand output register
  always_ff @(posedge CLK_DC) begin
    if (RESET) begin
      vld_p1_q  <= 1'b0;
      nreg_p1_q <= '0;
      data_p1_q <= '0;
      rerr_p1_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      nreg_p1_q <= nreg_p1_d;
      data_p1_q <= data_p1_d;
      rerr_p1_q <= rerr_p1_d;
    end
  end

  assign READY_OUT = ready;
  assign VALID_OUT = vld_p1_q;
  assign N_REG_OUT = nreg_p1_q;
  assign REG_OUT   = data_p1_q;
  assign RANGE_ERR = rerr_p1_q;

endmodule

// File: tb/tb_reg_dc_mp.sv
// Directed bench for reg_dc_mp: default instance plus a NUM_REGS=6 instance.
module tb_reg_dc_mp;

  logic CLK_DC = 1'b0;
  logic RESET;
  always #5 CLK_DC = ~CLK_DC;

  logic        va, ra, wbe, vo, ri;
  logic [5:0]  nra, nro;
  logic [127:0] regsa;
  logic [2:0]  nwb;
  logic [15:0] wbd;
  logic [31:0] ro;
  logic [1:0]  re;

  logic        vb, rb, wbeb, vob, rib;
  logic [5:0]  nrb, nrob;
  logic [95:0] regsb;
  logic [2:0]  nwbb;
  logic [15:0] wbdb;
  logic [31:0] rob;
  logic [1:0]  reb;

  int vectors = 0;
  int miscmp  = 0;

  reg_dc_mp u_dut (
    .CLK_DC(CLK_DC), .RESET(RESET), .VALID_IN(va), .READY_OUT(ra),
    .N_REG_IN(nra), .REGS_IN(regsa), .WB_EN(wbe), .N_WB(nwb), .WB_DATA(wbd),
    .VALID_OUT(vo), .READY_IN(ri), .N_REG_OUT(nro), .REG_OUT(ro), .RANGE_ERR(re)
  );

  reg_dc_mp #(.DATA_W(16), .NUM_REGS(6), .ADDR_W(3), .NUM_RD(2)) u_dut6 (
    .CLK_DC(CLK_DC), .RESET(RESET), .VALID_IN(vb), .READY_OUT(rb),
    .N_REG_IN(nrb), .REGS_IN(regsb), .WB_EN(wbeb), .N_WB(nwbb), .WB_DATA(wbdb),
    .VALID_OUT(vob), .READY_IN(rib), .N_REG_OUT(nrob), .REG_OUT(rob), .RANGE_ERR(reb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_DC);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    va = 0; ri = 1; nra = '0; wbe = 0; nwb = '0; wbd = '0;
    vb = 0; rib = 1; nrb = '0; wbeb = 0; nwbb = '0; wbdb = '0;
    for (int r = 0; r < 8; r++) regsa[r*16 +: 16] = 16'h1000 + 16'(r);
    for (int r = 0; r < 6; r++) regsb[r*16 +: 16] = 16'h1000 + 16'(r);

    // reset state
    step();
    chk("rst_valid", 64'(vo), 64'd0);
    chk("rst_regout", 64'(ro), 64'd0);
    chk("rst_nreg", 64'(nro), 64'd0);
    chk("rst_rerr", 64'(re), 64'd0);
    chk("rst_ready", 64'(ra), 64'd0);
    chk("rst_valid_b", 64'(vob), 64'd0);

    // basic read {3,5}
    RESET = 0;
    #1;
    chk("ready_after_rst", 64'(ra), 64'd1);
    va = 1; nra = {3'd5, 3'd3};
    step();
    chk("basic_valid", 64'(vo), 64'd1);
    chk("basic_regout", 64'(ro), 64'h1005_1003);
    chk("basic_nreg", 64'(nro), 64'(6'b101_011));
    chk("basic_rerr", 64'(re), 64'd0);

    // back-to-back accept {1,2}, then 3-cycle stall
    nra = {3'd2, 3'd1};
    step();
    chk("b2b_regout", 64'(ro), 64'h1002_1001);
    chk("b2b_valid", 64'(vo), 64'd1);
    ri = 0; nra = {3'd7, 3'd6};
    #1;
    chk("stall_ready", 64'(ra), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 64'(vo), 64'd1);
      chk("stall_regout", 64'(ro), 64'h1002_1001);
      chk("stall_nreg", 64'(nro), 64'(6'b010_001));
    end
    ri = 1;
    #1;
    chk("release_ready", 64'(ra), 64'd1);
    step();
    chk("nobubble_valid", 64'(vo), 64'd1);
    chk("nobubble_regout", 64'(ro), 64'h1007_1006);

    // accept-time bypass {4,4}
    nra = {3'd4, 3'd4}; wbe = 1; nwb = 3'd4; wbd = 16'hBEEF;
    regsa[4*16 +: 16] = 16'h0004;
    step();
`ifdef REG_DC_MP_BYPASS_EN
    chk("acc_bypass", 64'(ro), 64'hBEEF_BEEF);
`else
    chk("acc_bypass", 64'(ro), 64'h0004_0004);
`endif

    // stall-time refresh with held {6,2}
    nra = {3'd2, 3'd6}; wbe = 0;
    step();
    chk("hold62_regout", 64'(ro), 64'h1002_1006);
    ri = 0; va = 0; wbe = 1; nwb = 3'd2; wbd = 16'h00AA;
    regsa[6*16 +: 16] = 16'h7777;
    step();
`ifdef REG_DC_MP_BYPASS_EN
    chk("stall_refresh", 64'(ro), 64'h00AA_1006);
`else
    chk("stall_refresh", 64'(ro), 64'h1002_1006);
`endif
    chk("stall_refresh_nreg", 64'(nro), 64'(6'b010_110));

    // reset during stall
    RESET = 1;
    #1;
    chk("rst_hi_ready", 64'(ra), 64'd0);
    step();
    chk("midrst_valid", 64'(vo), 64'd0);
    chk("midrst_regout", 64'(ro), 64'd0);
    chk("midrst_nreg", 64'(nro), 64'd0);
    chk("midrst_ready", 64'(ra), 64'd0);
    RESET = 0; va = 1; wbe = 0; nra = {3'd1, 3'd0};
    #1;
    chk("postrst_ready", 64'(ra), 64'd1);
    step();
    chk("postrst_valid", 64'(vo), 64'd1);
    chk("postrst_regout", 64'(ro), 64'h1001_1000);
    va = 0; ri = 1;
    step();
    chk("drain_valid", 64'(vo), 64'd0);
    chk("drain_retain", 64'(ro), 64'h1001_1000);
    chk("drain_nreg", 64'(nro), 64'(6'b001_000));

    // NUM_REGS=6: out-of-range index 7 on port0
    vb = 1; rib = 1; nrb = {3'd5, 3'd7}; wbeb = 1; nwbb = 3'd7; wbdb = 16'hDEAD;
    step();
    chk("oor_valid", 64'(vob), 64'd1);
    chk("oor_regout", 64'(rob), 64'h1005_0000);
    chk("oor_rerr", 64'(reb), 64'd1);
    vb = 0; rib = 0;
    step();
    chk("oor_stall_regout", 64'(rob), 64'h1005_0000);
    chk("oor_stall_rerr", 64'(reb), 64'd1);
    vb = 1; rib = 1; wbeb = 0; nrb = {3'd6, 3'd2};
    step();
    chk("oor6_regout", 64'(rob), 64'h0000_1002);
    chk("oor6_rerr", 64'(reb), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule

// File: doc/reg_dc_mp.md
REG_DC_MP -- requirements
Module: reg_dc_mp

Interface
REQ-001 Parameter DATA_W, default 16, register data width in bits.
REQ-002 Parameter NUM_REGS, default 8, number of architectural registers (2..256, not necessarily a power of two).
REQ-003 Parameter ADDR_W, default 3, register index width; SHALL satisfy 2**ADDR_W >= NUM_REGS.
REQ-004 Parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-005 CLK_DC  in  1  decode-stage clock; all state changes on its rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 VALID_IN  in  1  upstream holds a decoded instruction.
REQ-008 READY_OUT  out  1  block can accept this cycle.
REQ-009 N_REG_IN  in  NUM_RD*ADDR_W  read indices; port p at bits [p*ADDR_W +: ADDR_W].
REQ-010 REGS_IN  in  NUM_REGS*DATA_W  flattened register file; register r at bits [r*DATA_W +: DATA_W].
REQ-011 WB_EN  in  1  write-back strobe this cycle.
REQ-012 N_WB  in  ADDR_W  write-back register index.
REQ-013 WB_DATA  in  DATA_W  write-back data.
REQ-014 VALID_OUT  out  1  registered operands are valid.
REQ-015 READY_IN  in  1  downstream accepts this cycle.
REQ-016 N_REG_OUT  out  NUM_RD*ADDR_W  registered copy of the accepted indices.
REQ-017 REG_OUT  out  NUM_RD*DATA_W  registered operand per port, same packing as N_REG_IN.
REQ-018 RANGE_ERR  out  NUM_RD  per-port flag: accepted index >= NUM_REGS.

Function
REQ-019 READY_OUT SHALL equal (!VALID_OUT || READY_IN) && !RESET, combinationally.
REQ-020 Accept occurs on a rising edge with VALID_IN && READY_OUT; latency from accept to VALID_OUT=1 SHALL be exactly one cycle.
REQ-021 On accept, per port p: N_REG_OUT[p] <= N_REG_IN[p]; REG_OUT[p] <= register N_REG_IN[p] of REGS_IN; RANGE_ERR[p] <= (N_REG_IN[p] >= NUM_REGS).
REQ-022 Out-of-range index SHALL load REG_OUT[p] with all zeros.
REQ-023 VALID_OUT next value: 1 on accept; 0 when VALID_OUT && READY_IN with no accept; otherwise unchanged.
REQ-024 While VALID_OUT && !READY_IN (stall), N_REG_OUT, RANGE_ERR and VALID_OUT SHALL hold; REG_OUT holds except as in REQ-027.
REQ-025 When VALID_OUT falls, N_REG_OUT/REG_OUT/RANGE_ERR SHALL retain their last values.
REQ-026 Simultaneous consume and accept in one cycle SHALL produce back-to-back VALID_OUT=1 with the new entry and no bubble.

Reset
REQ-027 (see Configuration) refresh behaviour is defined there; reset overrides it.
REQ-028 RESET high at a rising edge SHALL set VALID_OUT=0, N_REG_OUT=0, REG_OUT=0, RANGE_ERR=0, overriding accept, stall and write-back.
REQ-029 An entry held mid-stall when RESET asserts SHALL be discarded; first accept is possible on the first edge after RESET deasserts.

Configuration
REQ-030 Macro REG_DC_MP_BYPASS_EN, when defined: on accept, any port with WB_EN && N_WB == N_REG_IN[p] && N_WB < NUM_REGS SHALL load WB_DATA instead of REGS_IN.
REQ-031 With REG_DC_MP_BYPASS_EN defined, during stall any held port with WB_EN && N_WB == N_REG_OUT[p] && !RANGE_ERR[p] SHALL update REG_OUT[p] <= WB_DATA.
REQ-032 Without REG_DC_MP_BYPASS_EN, WB_EN/N_WB/WB_DATA SHALL have no effect; operands come solely from REGS_IN.

Verification
REQ-033 Defaults, REGS_IN reg r = 16'h1000+r, N_REG_IN={3,5}, VALID_IN=1, READY_IN=1 -> next cycle VALID_OUT=1, REG_OUT={16'h1003,16'h1005}, RANGE_ERR=0.
REQ-034 Accept {1,2}, then READY_IN=0 for 3 cycles with VALID_IN=1 -> READY_OUT=0, outputs stable 3 cycles; READY_IN=1 -> next entry appears next edge, no bubble.
REQ-035 BYPASS_EN: accept N_REG_IN={4,4} with WB_EN=1, N_WB=4, WB_DATA=16'hBEEF, REGS_IN reg4=16'h0004 -> REG_OUT={16'hBEEF,16'hBEEF}; macro undefined -> {16'h0004,16'h0004}.
REQ-036 BYPASS_EN: stall holding N_REG_OUT={6,2}, WB_EN=1, N_WB=2, WB_DATA=16'h00AA -> REG_OUT port1 becomes 16'h00AA next edge, port0 unchanged.
REQ-037 NUM_REGS=6, ADDR_W=3: accept index 7 on port0 -> REG_OUT port0=0, RANGE_ERR[0]=1; WB_EN with N_WB=7 has no effect.
REQ-038 RESET high during stall with VALID_OUT=1 -> next edge all outputs 0, READY_OUT=0 while RESET high, =1 the cycle after release.
